// File: rtl/mul_hilo_unit.sv
// Shift-and-add unsigned multiplier that commits its 2*WIDTH product into HI/LO.
// Fixed WIDTH-cycle latency; stall holds mulu/mfhi/mflo back while a multiply runs.
module mul_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             rd_req,
  input  logic             rd_hi,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  typedef struct packed {
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
  } mul_st_t;

  logic [0:0]         state;
  mul_st_t            st;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               last;

  assign acc_nxt = st.mplier[0] ? st.acc + st.mcand : st.acc;
  assign last    = (st.cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      st    <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            st.acc    <= '0;
            st.mcand  <= {{WIDTH{1'b0}}, srca};
            st.mplier <= srcb;
            st.cnt    <= '0;
            state     <= S_RUN;
          end
        end
        default: begin
          st.acc    <= acc_nxt;
          st.mcand  <= st.mcand << 1;
          st.mplier <= st.mplier >> 1;
          st.cnt    <= st.cnt + CNT_W'(1);
          // Commit includes this edge's partial product add.
          if (last) begin
            {hi, lo} <= acc_nxt;
            state    <= S_IDLE;
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy    = (state == S_RUN);
  assign stall   = busy & (start | rd_req);
  assign rd_data = rd_hi ? hi : lo;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Randomized self-checking bench for mul_hilo_unit against an arithmetic HI/LO model.
module tb_mul_hilo_unit;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset, start, rd_req, rd_hi;
  logic [WIDTH-1:0] srca, srcb, rd_data, hi, lo;
  logic             busy, done, stall;

  int vectors = 0;
  int errs    = 0;
  logic [WIDTH-1:0] m_hi = '0, m_lo = '0;

  mul_hilo_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .srca(srca), .srcb(srcb),
    .rd_req(rd_req), .rd_hi(rd_hi), .rd_data(rd_data), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = 64'(a) * 64'(b);
    m_hi = p[2*WIDTH-1:WIDTH];
    m_lo = p[WIDTH-1:0];
  endtask

  // Issue one multiply from idle (with a same-cycle mfhi/mflo) and follow it to completion.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int cyc;
    logic [WIDTH-1:0] old_hi, old_lo;
    old_hi = m_hi; old_lo = m_lo;
    start = 1'b1; srca = a; srcb = b;
    rd_req = 1'b1; rd_hi = 1'($urandom);
    #1;
    vectors++;
    if (rd_data !== (rd_hi ? old_hi : old_lo) || stall !== 1'b0) begin
      errs++; $display("FAIL idle_rd_with_start: rd_data=%h stall=%b want %h/0", rd_data, stall, rd_hi ? old_hi : old_lo);
    end
    tick();
    start = 1'b0; rd_req = 1'b0;
    srca = $urandom; srcb = $urandom;
    model_mul(a, b);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      vectors++;
      if (hi !== old_hi || lo !== old_lo || done !== 1'b0) begin
        errs++; $display("FAIL hold_during_run: hi=%h lo=%h done=%b want %h %h 0", hi, lo, done, old_hi, old_lo);
      end
      tick(); cyc++;
    end
    vectors++;
    if (cyc !== WIDTH) begin
      errs++; $display("FAIL busy_len: got %0d cycles want %0d", cyc, WIDTH);
    end
    vectors++;
    if (done !== 1'b1 || hi !== m_hi || lo !== m_lo) begin
      errs++; $display("FAIL result %h*%h: done=%b hi=%h lo=%h want 1 %h %h", a, b, done, hi, lo, m_hi, m_lo);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++; $display("FAIL done_pulse: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rd_req = 1'b0; rd_hi = 1'b0; srca = '0; srcb = '0;
    tick(); tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0 || stall !== 1'b0) begin
      errs++; $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h stall=%b", busy, done, hi, lo, stall);
    end
  endtask

  task automatic test_basic();
    run_mul(32'd3, 32'd5);
    rd_hi = 1'b0; #1;
    vectors++;
    if (rd_data !== 32'd15) begin
      errs++; $display("FAIL basic_rd_lo: rd_data=%h want 0000000f", rd_data);
    end
  endtask

  task automatic test_corners();
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vectors++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errs++; $display("FAIL max_operands: hi=%h lo=%h want fffffffe 00000001", hi, lo);
    end
    run_mul(32'h8000_0000, 32'd2);
    vectors++;
    if (hi !== 32'd1 || lo !== 32'd0) begin
      errs++; $display("FAIL carry_to_hi: hi=%h lo=%h want 1 0", hi, lo);
    end
    run_mul(32'd0, 32'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) run_mul($urandom, $urandom);
  endtask

  task automatic test_start_while_busy();
    int cyc;
    run_mul(32'd1, 32'd1);
    start = 1'b1; srca = 32'd7; srcb = 32'd9;
    tick();
    for (int i = 0; i < 4; i++) tick();
    srca = 32'd2; srcb = 32'd2;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      vectors++;
      if (stall !== 1'b1 || lo !== 32'd1) begin
        errs++; $display("FAIL start_busy_stall: stall=%b lo=%h want 1 1", stall, lo);
      end
      tick(); cyc++;
    end
    vectors++;
    if (done !== 1'b1 || hi !== 32'd0 || lo !== 32'd63 || stall !== 1'b0) begin
      errs++; $display("FAIL first_result: done=%b hi=%h lo=%h stall=%b want 1 0 3f 0", done, hi, lo, stall);
    end
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errs++; $display("FAIL accept_in_done: busy=%b done=%b want 1 0", busy, done);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin tick(); cyc++; end
    vectors++;
    if (cyc !== WIDTH || done !== 1'b1 || hi !== 32'd0 || lo !== 32'd4) begin
      errs++; $display("FAIL second_result: cyc=%0d done=%b hi=%h lo=%h want 32 1 0 4", cyc, done, hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'd4;
    tick();
  endtask

  task automatic test_rd_while_busy();
    int cyc;
    run_mul(32'd3, 32'd5);
    start = 1'b1; srca = 32'd6; srcb = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rd_req = 1'b1; rd_hi = 1'b0;
    #1;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      vectors++;
      if (stall !== 1'b1 || rd_data !== 32'd15) begin
        errs++; $display("FAIL rd_busy: stall=%b rd_data=%h want 1 0000000f", stall, rd_data);
      end
      tick(); cyc++;
    end
    vectors++;
    if (stall !== 1'b0 || rd_data !== 32'd42 || hi !== 32'd0 || done !== 1'b1) begin
      errs++; $display("FAIL rd_after_done: stall=%b rd_data=%h hi=%h done=%b want 0 2a 0 1", stall, rd_data, hi, done);
    end
    rd_req = 1'b0;
    m_hi = 32'd0; m_lo = 32'd42;
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    start = 1'b1; srca = 32'd123; srcb = 32'd456;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
      errs++; $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    vectors++;
    if (seen !== 0) begin
      errs++; $display("FAIL aborted_activity: %0d active cycles want 0", seen);
    end
    run_mul($urandom, $urandom);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_start_while_busy();
    test_rd_while_busy();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/mul_hilo_unit.md
Name: mul_hilo_unit

Overview:
Multi-cycle unsigned multiplier with architectural HI/LO registers. It sits downstream of the instruction decoder, beside the ALU. It consumes the decoder's mulu / mfhi / mflo classification (alucontrol 011 / 100 / 101) plus the register-file operands. It produces HI/LO read data and a stall request that freezes the pipeline while a multiply is in flight.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH, and one multiply takes WIDTH iterations
CNT_W, 5, iteration counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  issue mulu this cycle (decoder alucontrol==011 on a valid instruction)
srca  input  WIDTH  multiplicand (rs), unsigned
srcb  input  WIDTH  multiplier (rt), unsigned
rd_req  input  1  mfhi/mflo issued this cycle
rd_hi  input  1  1 = read HI (mfhi), 0 = read LO (mflo)
rd_data  output  WIDTH  combinational: rd_hi ? hi : lo
hi  output  WIDTH  architectural HI register
lo  output  WIDTH  architectural LO register
busy  output  1  multiply in progress
done  output  1  one-cycle pulse; HI/LO updated on the previous edge
stall  output  1  combinational: busy & (start | rd_req)

Behaviour:
- Reset (sync, highest priority): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulator/shift regs=0. An in-flight multiply is aborted and its result discarded.
- States: IDLE, RUN. busy = (state==RUN), registered.
- IDLE, start=1 at edge E0:
  - mcand <= {WIDTH zeros, srca} (2*WIDTH bits)
  - mplier <= srcb
  - acc <= 0, cnt <= 0
  - state <= RUN
- IDLE, start=0: hold all.
- RUN, each edge:
  - if mplier[0]: acc <= acc + mcand, computed mod 2**(2*WIDTH)
  - mcand <= mcand << 1
  - mplier <= mplier >> 1
  - cnt <= cnt + 1
- RUN, edge with cnt==WIDTH-1 (the WIDTH-th iteration):
  - {hi,lo} <= final acc, including this iteration's add
  - state <= IDLE, done <= 1 for exactly the next cycle
- Latency: fixed. busy is high for exactly WIDTH cycles (32) after E0. done is high in cycle E0+WIDTH+1. No early termination, even for zero operands.
- done clears on the following edge unless a new multiply completes then; two completions can never be adjacent.
- hi/lo hold their previous values throughout RUN and change only on the completion edge or on reset.
- rd_data always reflects committed hi/lo, never the partial accumulator.
- start while busy:
  - ignored (no operand latch, no restart); stall=1.
  - The pipeline holds the instruction, so start stays asserted until busy drops, then it is accepted in IDLE.
- rd_req while busy: stall=1 (mfhi/mflo must wait for completion). rd_req while idle: stall=0, rd_data valid the same cycle.
- start in the done cycle (state already IDLE): accepted normally. Back-to-back multiplies have a 1-cycle gap in busy at most.
- start and rd_req both asserted while IDLE: legal. rd_data returns the old hi/lo this cycle and the multiply starts.
- Operands are sampled only at E0; srca/srcb changes during RUN have no effect.

Test Plan:
- Reset, then start with srca=3, srcb=5 → busy=1 for 32 cycles; done pulse at cycle 33; hi=0, lo=15; rd_hi=0 gives rd_data=15.
- srca=FFFFFFFF, srcb=FFFFFFFF → hi=FFFFFFFE, lo=00000001. Also srca=80000000, srcb=2 → hi=1, lo=0.
- Start 7×9, then at cycle 5 assert start with srca=2, srcb=2 held until busy drops → stall=1 while busy; first result lo=63 committed; second multiply accepted in the done cycle; final lo=4.
- Prior hi/lo=(0,15); start 6×7, assert rd_req at cycle 10 → stall=1 and rd_data=15 (old value) through cycle 32. After done, lo=42 and stall=0.
- Start 123×456, assert reset at cycle 10 → next edge: busy=0, done=0, hi=lo=0; no done pulse follows; a new start works normally.
- srca=0, srcb=0 → still exactly 32 busy cycles; hi=lo=0; done pulses once.
